// File: rtl/dadda_tree.sv
// Dadda carry-save reduction of six radix-4 Booth partial products into one registered 20-bit product.
// Optional input register enabled by the DADDA_IN_REG_EN macro (latency 2 instead of 1).
module dadda_tree #(
   parameter int unsigned N_OPS = 6,
   parameter int unsigned OP_W  = 13,
   parameter int unsigned RES_W = 20,
   parameter int unsigned SHIFT = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_OPS-1:0][OP_W-1:0]     ops,
   output logic [RES_W-1:0]               result
);

   localparam int unsigned COL_D = N_OPS;
   localparam int unsigned CW    = $clog2(RES_W);
   localparam int unsigned HW    = $clog2(COL_D);
   localparam int unsigned IW    = $clog2(N_OPS);
   localparam int unsigned BW    = $clog2(OP_W);

   logic [N_OPS-1:0][OP_W-1:0] ops_t;
   logic [RES_W-1:0]           row_a;
   logic [RES_W-1:0]           row_b;
   logic [RES_W-1:0]           sum_c;

`ifdef DADDA_IN_REG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ops_t <= '0;
      else      ops_t <= ops;
   end
`else
   assign ops_t = ops;
`endif

   // Column-wise Dadda reduction; heights and adder placement fold to constants, only the bit wiring is real.
   always_comb begin : tree
      logic [COL_D-1:0] cur   [RES_W];
      logic [COL_D-1:0] nxt   [RES_W];
      int               cur_h [RES_W];
      int               nxt_h [RES_W];
      int               d;
      int               r;
      int               idx;
      int               pos;
      logic [CW-1:0]    cc;
      logic [CW-1:0]    cn;
      logic             a;
      logic             b;
      logic             ci;

      d   = 0;
      r   = 0;
      idx = 0;
      pos = 0;
      cc  = '0;
      cn  = '0;
      a   = 1'b0;
      b   = 1'b0;
      ci  = 1'b0;
      row_a = '0;
      row_b = '0;
      for (int c = 0; c < int'(RES_W); c++) begin
         cur[c]   = '0;
         nxt[c]   = '0;
         cur_h[c] = 0;
         nxt_h[c] = 0;
      end

      // Stack every partial-product bit into its weight column; bits at or above RES_W are dropped.
      for (int i = 0; i < int'(N_OPS); i++) begin
         for (int j = 0; j < int'(OP_W); j++) begin
            pos = int'(SHIFT) * i + j;
            if (pos < int'(RES_W)) begin
               cc = CW'(pos);
               cur[cc][HW'(cur_h[cc])] = ops_t[IW'(i)][BW'(j)];
               cur_h[cc] = cur_h[cc] + 1;
            end
         end
      end

      for (int s = 0; s < 3; s++) begin
         d = (s == 0) ? 4 : ((s == 1) ? 3 : 2);
         for (int c = 0; c < int'(RES_W); c++) begin
            nxt[c]   = '0;
            nxt_h[c] = 0;
         end
         for (int c = 0; c < int'(RES_W); c++) begin
            cc  = CW'(c);
            cn  = CW'(c + 1);
            idx = 0;
            r   = cur_h[cc] + nxt_h[cc];
            // Fewest adders that bring this column (including incoming carries) down to d.
            for (int k = 0; k < int'(COL_D); k++) begin
               if ((r - d >= 2) && (cur_h[cc] - idx >= 3)) begin
                  a  = cur[cc][HW'(idx)];
                  b  = cur[cc][HW'(idx + 1)];
                  ci = cur[cc][HW'(idx + 2)];
                  nxt[cc][HW'(nxt_h[cc])] = a ^ b ^ ci;
                  nxt_h[cc] = nxt_h[cc] + 1;
                  if (c + 1 < int'(RES_W)) begin
                     nxt[cn][HW'(nxt_h[cn])] = (a & b) | (ci & (a ^ b));
                     nxt_h[cn] = nxt_h[cn] + 1;
                  end
                  idx = idx + 3;
                  r   = r - 2;
               end else if ((r - d >= 1) && (cur_h[cc] - idx >= 2)) begin
                  a = cur[cc][HW'(idx)];
                  b = cur[cc][HW'(idx + 1)];
                  nxt[cc][HW'(nxt_h[cc])] = a ^ b;
                  nxt_h[cc] = nxt_h[cc] + 1;
                  if (c + 1 < int'(RES_W)) begin
                     nxt[cn][HW'(nxt_h[cn])] = a & b;
                     nxt_h[cn] = nxt_h[cn] + 1;
                  end
                  idx = idx + 2;
                  r   = r - 1;
               end
            end
            for (int k = 0; k < int'(COL_D); k++) begin
               if ((k >= idx) && (k < cur_h[cc])) begin
                  nxt[cc][HW'(nxt_h[cc])] = cur[cc][HW'(k)];
                  nxt_h[cc] = nxt_h[cc] + 1;
               end
            end
         end
         cur   = nxt;
         cur_h = nxt_h;
      end

      for (int c = 0; c < int'(RES_W); c++) begin
         cc        = CW'(c);
         row_a[cc] = cur[cc][0];
         row_b[cc] = cur[cc][1];
      end
   end

   // Final carry-propagate add; carry out of the top bit is discarded.
   assign sum_c = row_a + row_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) result <= '0;
      else      result <= sum_c;
   end

endmodule

// File: tb/tb_dadda_tree.sv
// Bench for dadda_tree: directed vector table, reset sequences and a random back-to-back stream
// checked against an arithmetic model of the weighted partial-product sum.
module tb_dadda_tree;

`ifdef DADDA_IN_REG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   typedef struct {
      logic [5:0][12:0] ops;
      logic [19:0]      exp;
      string            name;
   } vec_t;

   logic             clk;
   logic             rst;
   logic [5:0][12:0] ops;
   logic [19:0]      result;

   int n_checks = 0;
   int n_fail   = 0;

   dadda_tree dut (
      .clk    (clk),
      .rst    (rst),
      .ops    (ops),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] model(input logic [5:0][12:0] v);
      longint acc;
      acc = 0;
      for (int i = 0; i < 6; i++) acc += longint'(v[i]) << (2 * i);
      return 20'(acc);
   endfunction

   function automatic logic [5:0][12:0] rand_ops();
      logic [5:0][12:0] v;
      for (int i = 0; i < 6; i++) v[i] = 13'($urandom);
      return v;
   endfunction

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t             vecs [6];
      logic [5:0][12:0] v;
      logic [19:0]      exp_q [$];
      logic [19:0]      e;

      v = '0;                                   vecs[0] = '{v, 20'h00000, "all_zero"};
      v = '0; v[0] = 13'h0001;                  vecs[1] = '{v, 20'h00001, "op0_one"};
      v = '0; v[0] = 13'h000F;                  vecs[2] = '{v, 20'h0000F, "op0_f"};
      v = '0; v[5] = 13'h1FFF;                  vecs[3] = '{v, 20'hFFC00, "op5_trunc"};
      v = {6{13'h1FFF}};                        vecs[4] = '{v, 20'hA9AAB, "all_ones"};
      v = '0; v[1] = 13'h0001; v[3] = 13'h0002; vecs[5] = '{v, 20'h00084, "op1_op3"};

      // Asynchronous reset with random inputs
      rst = 1'b1;
      ops = rand_ops();
      #1 rst = 1'b0;
      #1 check("reset_async", result, 20'h00000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk) ops = rand_ops();
         @(posedge clk) #1 check("reset_hold", result, 20'h00000);
      end
      @(negedge clk);
      rst = 1'b1;
      ops = vecs[2].ops;
      #1 check("release_pre_edge", result, 20'h00000);
      repeat (L) @(posedge clk);
      #1 check("release_first", result, 20'h0000F);

      // Directed vector table
      for (int t = 0; t < 6; t++) begin
         @(negedge clk) ops = vecs[t].ops;
         repeat (L) @(posedge clk);
         #1 check(vecs[t].name, result, vecs[t].exp);
      end

      // Back-to-back random stream, one vector per cycle
      for (int j = 0; j < 10 + L - 1; j++) begin
         @(negedge clk);
         if (j < 10) begin
            ops = rand_ops();
            exp_q.push_back(model(ops));
         end
         @(posedge clk);
         #1;
         if (j >= L - 1) begin
            e = exp_q.pop_front();
            check($sformatf("stream_%0d", j - L + 1), result, e);
         end
      end

      // Reset asserted mid-stream discards the pending product
      @(negedge clk) ops = {6{13'h1FFF}};
      repeat (L) @(posedge clk);
      #1 check("pre_mid_reset", result, 20'hA9AAB);
      @(negedge clk) ops = rand_ops();
      @(posedge clk) #2 rst = 1'b0;
      #1 check("mid_reset_async", result, 20'h00000);
      repeat (2) @(posedge clk);
      #1 check("mid_reset_hold", result, 20'h00000);
      @(negedge clk);
      rst = 1'b1;
      ops = vecs[4].ops;
      #1 check("mid_release_pre_edge", result, 20'h00000);
      repeat (L) @(posedge clk);
      #1 check("mid_release_first", result, 20'hA9AAB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
